// File: rtl/serial_link_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_link_gen
// Description : WIDTH-bit MSB-first serial transceiver with SB/SC registers,
//               internal (normal/fast) or external shift clock, and a
//               transfer-complete interrupt pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_link_gen #(
  parameter int WIDTH      = 8,
  parameter int DIV_LOG2   = 9,
  parameter int FAST_SHIFT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_addr,
  input  logic             i_wr,
  input  logic             i_rd,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_rdata_oe,
  input  logic             i_sck_in,
  input  logic             i_sin,
  output logic             o_sck_out,
  output logic             o_sck_dir,
  output logic             o_ser_out,
  output logic             o_irq
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = DIV_LOG2;
  localparam logic [DW-1:0] c_HN_M1 = DW'((2 ** (DIV_LOG2 - 1)) - 1);
  localparam logic [DW-1:0] c_HF_M1 = DW'((2 ** (DIV_LOG2 - 1 - FAST_SHIFT)) - 1);
  localparam logic [CW-1:0] c_LAST  = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_sb;
  logic             r_fast;
  logic             r_intclk;
  logic             r_ser_out;
  logic             r_sck_out;
  logic             r_irq;
  logic [DW-1:0]    r_div;
  logic [CW-1:0]    r_bitcnt;
  logic             r_sck_s1, r_sck_s2, r_sck_d;
  logic             r_sin_s1, r_sin_s2;

  logic             w_active, w_sc_wr, w_sb_wr, w_wd7;
  logic             w_tick, w_ext_rise, w_ext_fall;
  logic             w_shift, w_fall, w_done, w_idle_like;
  logic             w_start, w_abort;
  logic [WIDTH-1:0] w_sb_shifted;
  logic [WIDTH-1:0] w_sc;
  logic [DW-1:0]    w_half_m1;

  // SC layout needs bit 7; narrow instances expose only FAST/INTCLK.
  generate
    if (WIDTH >= 8) begin : g_sc_wide
      assign w_wd7 = i_wdata[7];
      always_comb begin
        w_sc    = '1;
        w_sc[7] = w_active;
        w_sc[1] = r_fast;
        w_sc[0] = r_intclk;
      end
    end else begin : g_sc_narrow
      assign w_wd7 = 1'b0;
      always_comb begin
        w_sc    = '1;
        w_sc[1] = r_fast;
        w_sc[0] = r_intclk;
      end
    end
  endgenerate

  assign w_active     = (r_state == S_ACTIVE);
  assign w_sc_wr      = i_wr & i_addr;
  assign w_sb_wr      = i_wr & ~i_addr;
  assign w_half_m1    = r_fast ? c_HF_M1 : c_HN_M1;
  assign w_tick       = w_active & r_intclk & (r_div == '0);
  assign w_ext_rise   = r_sck_s2 & ~r_sck_d;
  assign w_ext_fall   = ~r_sck_s2 & r_sck_d;
  assign w_shift      = w_active & (r_intclk ? (w_tick & ~r_sck_out) : w_ext_rise);
  assign w_fall       = w_active & (r_intclk ? (w_tick & r_sck_out) : w_ext_fall);
  assign w_done       = w_shift & (r_bitcnt == c_LAST);
  // The completion cycle behaves as IDLE for register writes.
  assign w_idle_like  = ~w_active | w_done;
  assign w_start      = w_sc_wr & w_wd7 & w_idle_like;
  assign w_abort      = w_active & ~w_done & w_sc_wr & ~w_wd7;
  assign w_sb_shifted = {r_sb[WIDTH-2:0], r_sin_s2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_start)               w_state_nxt = S_ACTIVE;
        else if (w_done || w_abort) w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sb      <= '0;
      r_fast    <= 1'b0;
      r_intclk  <= 1'b0;
      r_ser_out <= 1'b1;
      r_sck_out <= 1'b1;
      r_irq     <= 1'b0;
      r_div     <= '0;
      r_bitcnt  <= '0;
      r_sck_s1  <= 1'b1;
      r_sck_s2  <= 1'b1;
      r_sck_d   <= 1'b1;
      r_sin_s1  <= 1'b1;
      r_sin_s2  <= 1'b1;
    end else begin
      r_sck_s1 <= i_sck_in;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_sin_s1 <= i_sin;
      r_sin_s2 <= r_sin_s1;
      r_irq    <= w_done;

      if (w_sb_wr && w_idle_like) r_sb <= i_wdata;
      else if (w_shift)           r_sb <= w_sb_shifted;

      if (w_sc_wr && (w_idle_like || !w_wd7)) begin
        r_fast   <= i_wdata[1];
        r_intclk <= i_wdata[0];
      end

      if (w_start)      r_bitcnt <= '0;
      else if (w_shift) r_bitcnt <= r_bitcnt + CW'(1);

      if (w_start)                    r_div <= '0;
      else if (w_active && r_intclk)  r_div <= (r_div == w_half_m1) ? '0 : r_div + DW'(1);

      if (w_done || w_abort) r_sck_out <= 1'b1;
      else if (w_tick)       r_sck_out <= ~r_sck_out;

      if (w_start)     r_ser_out <= w_done ? w_sb_shifted[WIDTH-1] : r_sb[WIDTH-1];
      else if (w_fall) r_ser_out <= r_sb[WIDTH-1];
    end
  end

  assign o_rdata    = i_addr ? w_sc : r_sb;
  assign o_rdata_oe = i_rd;
  assign o_sck_out  = r_sck_out;
  assign o_sck_dir  = r_intclk;
  assign o_ser_out  = r_ser_out;
  assign o_irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_serial_link_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_link_gen
// Description : Directed self-checking bench for serial_link_gen (WIDTH 8/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_link_gen;
  localparam int DL = 9;
  localparam int FS = 5;
  localparam int HN = 2 ** (DL - 1);
  localparam int HF = 2 ** (DL - 1 - FS);
  localparam int LEN_N8  = 2 * HN * 8 - HN + 1;
  localparam int LEN_F8  = 2 * HF * 8 - HF + 1;
  localparam int LEN_F16 = 2 * HF * 16 - HF + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        addr = 1'b0, wr = 1'b0, rd = 1'b0, sck_in = 1'b1, sin = 1'b1;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        rdata_oe, sck_out, sck_dir, ser_out, irq;

  logic        addr16 = 1'b0, wr16 = 1'b0, rd16 = 1'b0, sck_in16 = 1'b1, sin16 = 1'b1;
  logic [15:0] wdata16 = '0;
  logic [15:0] rdata16;
  logic        rdata_oe16, sck_out16, sck_dir16, ser_out16, irq16;

  serial_link_gen #(.WIDTH(8), .DIV_LOG2(DL), .FAST_SHIFT(FS)) dut (
    .clk(clk), .reset(reset), .i_addr(addr), .i_wr(wr), .i_rd(rd), .i_wdata(wdata),
    .o_rdata(rdata), .o_rdata_oe(rdata_oe), .i_sck_in(sck_in), .i_sin(sin),
    .o_sck_out(sck_out), .o_sck_dir(sck_dir), .o_ser_out(ser_out), .o_irq(irq));

  serial_link_gen #(.WIDTH(16), .DIV_LOG2(DL), .FAST_SHIFT(FS)) dut16 (
    .clk(clk), .reset(reset), .i_addr(addr16), .i_wr(wr16), .i_rd(rd16), .i_wdata(wdata16),
    .o_rdata(rdata16), .o_rdata_oe(rdata_oe16), .i_sck_in(sck_in16), .i_sin(sin16),
    .o_sck_out(sck_out16), .o_sck_dir(sck_dir16), .o_ser_out(ser_out16), .o_irq(irq16));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, last_rise = 0, rise_period = 0, rise_cnt = 0, irq_cnt = 0;
  logic prev_sck = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input string tag, input logic [31:0] v, input int w, input int n);
    exp_t e;
    for (int i = w - 1; i >= w - n; i--) begin
      e.tag = $sformatf("%s_bit%0d", tag, i);
      e.val = {31'd0, v[i]};
      sb_q.push_back(e);
    end
  endtask

  // One clock; every 0->1 of sck_out pops the next expected serial bit.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (irq) irq_cnt++;
    if (!prev_sck && sck_out) begin
      rise_cnt++;
      rise_period = cyc - last_rise;
      last_rise   = cyc;
      n_checks++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL ser_out_extra_rise: observed=%0d expected=>0 queued", sb_q.size());
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, {31'd0, ser_out}, e.val);
      end
    end
    prev_sck = sck_out;
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
    tick();
    wr    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic a, input logic [31:0] exp);
    addr = a;
    rd   = 1'b1;
    #1;
    check(tag, {24'd0, rdata}, exp);
    check({tag, "_oe"}, {31'd0, rdata_oe}, 32'd1);
    rd   = 1'b0;
  endtask

  task automatic wait_irq(input int budget, output int e);
    e = 0;
    do begin
      tick();
      e++;
    end while (!irq && e < budget);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   e;
    int   base;
    exp_t x;
    logic [7:0] pat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_out", {31'd0, ser_out}, 32'd1);
    check("rst_sck_out", {31'd0, sck_out}, 32'd1);
    check("rst_sck_dir", {31'd0, sck_dir}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_sb", 1'b0, 32'h00);
    rd_chk("rst_sc", 1'b1, 32'h7C);
    reset = 1'b0;
    tick();

    // Internal, normal rate
    sin = 1'b1;
    bus_wr(1'b0, 8'hA5);
    push_bits("norm", 32'hA5, 8, 8);
    bus_wr(1'b1, 8'h81);
    check("norm_sck_dir", {31'd0, sck_dir}, 32'd1);
    wait_irq(LEN_N8 + 100, e);
    check("norm_len", e, LEN_N8);
    tick();
    check("norm_irq_width", {31'd0, irq}, 32'd0);
    rd_chk("norm_sb", 1'b0, 32'hFF);
    rd_chk("norm_sc", 1'b1, 32'h7D);
    check("norm_bits_used", sb_q.size(), 0);

    // Internal, fast rate
    sin = 1'b0;
    bus_wr(1'b0, 8'h3C);
    push_bits("fast", 32'h3C, 8, 8);
    bus_wr(1'b1, 8'h83);
    wait_irq(LEN_F8 + 100, e);
    check("fast_len", e, LEN_F8);
    check("fast_period", rise_period, 2 * HF);
    rd_chk("fast_sb", 1'b0, 32'h00);
    rd_chk("fast_sc", 1'b1, 32'h7F);

    // External clock
    pat = 8'h5A;
    bus_wr(1'b0, 8'h81);
    push_bits("ext", 32'h81, 8, 8);
    bus_wr(1'b1, 8'h80);
    check("ext_sck_dir", {31'd0, sck_dir}, 32'd0);
    for (int i = 7; i >= 0; i--) begin
      sin    = pat[i];
      sck_in = 1'b0;
      repeat (4) tick();
      x = sb_q.pop_front();
      check(x.tag, {31'd0, ser_out}, x.val);
      check("ext_sck_out_hold", {31'd0, sck_out}, 32'd1);
      sck_in = 1'b1;
      if (i > 0) repeat (4) tick();
    end
    wait_irq(20, e);
    check("ext_irq_latency", e, 3);
    rd_chk("ext_sb", 1'b0, 32'h5A);

    // Abort after three rising edges
    sin = 1'b1;
    bus_wr(1'b0, 8'h96);
    push_bits("abort", 32'h96, 8, 3);
    bus_wr(1'b1, 8'h83);
    rise_cnt = 0;
    e = 0;
    while (rise_cnt < 3 && e < 200) begin
      tick();
      e++;
    end
    check("abort_rises", rise_cnt, 3);
    bus_wr(1'b1, 8'h01);
    base = irq_cnt;
    check("abort_sck_out", {31'd0, sck_out}, 32'd1);
    rd_chk("abort_sb", 1'b0, 32'hB7);
    rd_chk("abort_sc", 1'b1, 32'h7D);
    repeat (300) tick();
    check("abort_no_irq", irq_cnt - base, 0);

    // Reset mid-transfer
    sin = 1'b0;
    bus_wr(1'b0, 8'hC3);
    push_bits("rst", 32'hC3, 8, 4);
    bus_wr(1'b1, 8'h83);
    rise_cnt = 0;
    e = 0;
    while (rise_cnt < 4 && e < 200) begin
      tick();
      e++;
    end
    check("midrst_rises", rise_cnt, 4);
    e = 0;
    while (sck_out && e < 40) begin
      tick();
      e++;
    end
    check("midrst_sck_low", {31'd0, sck_out}, 32'd0);
    #2;
    reset    = 1'b1;
    prev_sck = 1'b1;
    #1;
    check("midrst_ser_out", {31'd0, ser_out}, 32'd1);
    check("midrst_sck_out", {31'd0, sck_out}, 32'd1);
    check("midrst_sck_dir", {31'd0, sck_dir}, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    rd_chk("midrst_sb", 1'b0, 32'h00);
    repeat (2) tick();
    reset = 1'b0;
    base  = irq_cnt;
    repeat (300) tick();
    check("midrst_no_irq", irq_cnt - base, 0);
    rd_chk("midrst_sc", 1'b1, 32'h7C);
    check("midrst_q_empty", sb_q.size(), 0);

    // Start write on the completion cycle
    sin = 1'b1;
    bus_wr(1'b0, 8'h0F);
    push_bits("sim1", 32'h0F, 8, 8);
    bus_wr(1'b1, 8'h83);
    repeat (LEN_F8 - 1) tick();
    push_bits("sim2", 32'hFF, 8, 8);
    base = irq_cnt;
    bus_wr(1'b1, 8'h83);
    check("sim_irq_at_done", {31'd0, irq}, 32'd1);
    rd_chk("sim_sc_active", 1'b1, 32'hFF);
    sin = 1'b0;
    wait_irq(LEN_F8 + 100, e);
    check("sim_second_len", e, LEN_F8);
    check("sim_irq_pulses", irq_cnt - base, 2);
    rd_chk("sim_sb", 1'b0, 32'h00);

    // SB write on the completion cycle lands after the final shift
    bus_wr(1'b0, 8'h12);
    push_bits("sbw", 32'h12, 8, 8);
    bus_wr(1'b1, 8'h83);
    repeat (LEN_F8 - 1) tick();
    bus_wr(1'b0, 8'h5C);
    check("sbw_irq", {31'd0, irq}, 32'd1);
    rd_chk("sbw_sb", 1'b0, 32'h5C);
    rd_chk("sbw_sc_idle", 1'b1, 32'h7F);

    // WIDTH=16 instance, fast internal clock
    sin16   = 1'b1;
    addr16  = 1'b0;
    wdata16 = 16'hA5C3;
    wr16    = 1'b1;
    tick();
    addr16  = 1'b1;
    wdata16 = 16'h0083;
    tick();
    wr16    = 1'b0;
    e = 0;
    do begin
      tick();
      e++;
    end while (!irq16 && e < LEN_F16 + 100);
    check("w16_len", e, LEN_F16);
    addr16 = 1'b0;
    rd16   = 1'b1;
    #1;
    check("w16_sb", {16'd0, rdata16}, 32'hFFFF);
    check("w16_sck_out", {31'd0, sck_out16}, 32'd1);
    rd16   = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
